// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Optional divider: define MDU_DIV_EN to build DIV/DIVU and div_zero; otherwise those ops are no-ops.
module mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc, acc_step, prod;
    logic [XLEN-1:0]     opnd, mag_a, mag_b, res_hi, res_lo;
    logic [XLEN:0]       mul_sum;
    logic                neg_lo, is_mul_op, is_div_op, accept, a_neg, b_neg;
`ifdef MDU_DIV_EN
    logic                is_div, dz, neg_hi;
    logic [XLEN-1:0]     a_raw;
    logic [XLEN:0]       div_sh;
    logic                div_ge;
`endif

    assign is_mul_op = start && (op == OP_MULT || op == OP_MULTU);
`ifdef MDU_DIV_EN
    assign is_div_op = start && (op == OP_DIV || op == OP_DIVU);
`else
    assign is_div_op = 1'b0;
`endif
    assign accept = (state == IDLE) && (is_mul_op || is_div_op);

    // Even opcodes (MULT, DIV) are the signed variants.
    assign a_neg = ~op[0] & src_a[XLEN-1];
    assign b_neg = ~op[0] & src_b[XLEN-1];
    assign mag_a = a_neg ? -src_a : src_a;
    assign mag_b = b_neg ? -src_b : src_b;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (cnt == CW'(XLEN - 1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
`ifdef MDU_DIV_EN
    assign div_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge = div_sh >= {1'b0, opnd};
`endif

    always_comb begin
        acc_step = {mul_sum, acc[XLEN-1:1]};
`ifdef MDU_DIV_EN
        if (is_div)
            acc_step = div_ge ? {div_sh[XLEN-1:0] - opnd, acc[XLEN-2:0], 1'b1}
                              : {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
`endif
    end

    assign prod = neg_lo ? -acc : acc;

    always_comb begin
        res_hi = prod[2*XLEN-1:XLEN];
        res_lo = prod[XLEN-1:0];
`ifdef MDU_DIV_EN
        if (is_div) begin
            if (dz) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
                res_lo = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg_lo <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        opnd   <= is_div_op ? mag_b : mag_a;
                        acc    <= {{XLEN{1'b0}}, (is_div_op ? mag_a : mag_b)};
                        neg_lo <= a_neg ^ b_neg;
                    end else if (start && op == OP_MTHI) begin
                        hi   <= src_a;
                        done <= 1'b1;
                    end else if (start && op == OP_MTLO) begin
                        lo   <= src_a;
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIN: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MDU_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_div   <= 1'b0;
            dz       <= 1'b0;
            neg_hi   <= 1'b0;
            a_raw    <= '0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= (state == FIN) && is_div && dz;
            if (accept) begin
                is_div <= is_div_op;
                dz     <= (src_b == '0);
                neg_hi <= a_neg;
                a_raw  <= src_a;
            end
        end
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written corner sequences,
// and randomized operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk, rst, start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       name;
    } vec_t;

    vec_t vecs[10];

    mult_div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: MIPS semantics straight from integer arithmetic.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mh, output logic [31:0] ml, output logic mdz);
        longint sa, sb, q, r;
        logic [63:0] p, ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        mdz = 1'b0;
        mh = '0;
        ml = '0;
        case (o)
            OP_MULT:  begin p = sa * sb; mh = p[63:32]; ml = p[31:0]; end
            OP_MULTU: begin p = ua * ub; mh = p[63:32]; ml = p[31:0]; end
            default: begin
                if (b == 0) begin
                    mh = a; ml = 32'hFFFF_FFFF; mdz = 1'b1;
                end else if (o == OP_DIV) begin
                    q = sa / sb; r = sa % sb;
                    ml = q[31:0]; mh = r[31:0];
                end else begin
                    ml = a / b; mh = a % b;
                end
            end
        endcase
    endfunction

    // Drive a one-cycle start; returns #1 after the accept edge E0.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs one MULT/DIV-class op; inj > 0 pokes an MTLO 0x1234 at edge E<inj> while busy.
    task automatic do_md(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int inj);
        bit runs, got;
        int lat, bad_busy, bad_hold;
        runs = !(o == OP_DIV || o == OP_DIVU) || DIV_EN;
        got = 1'b0; lat = 0; bad_busy = 0; bad_hold = 0;
        issue(o, a, b);
        check({name, "_busy_e0"}, busy, runs);
        for (int k = 1; k <= 40 && !got; k++) begin
            if (k == inj) begin
                start = 1'b1; op = OP_MTLO; src_a = 32'h1234;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                got = 1'b1; lat = k;
            end else begin
                if (busy !== runs || div_zero !== 1'b0) bad_busy++;
                if (hi !== model_hi || lo !== model_lo) bad_hold++;
            end
        end
        check({name, "_busy_during"}, bad_busy, 0);
        check({name, "_hilo_hold"}, bad_hold, 0);
        if (runs) begin
            check({name, "_latency"}, lat, 33);
            check({name, "_busy_end"}, busy, 0);
            check({name, "_hi"}, hi, ehi);
            check({name, "_lo"}, lo, elo);
            check({name, "_div_zero"}, div_zero, edz);
            model_hi = ehi;
            model_lo = elo;
            @(posedge clk); #1;
            check({name, "_done_clr"}, done, 0);
            check({name, "_dz_clr"}, div_zero, 0);
        end else begin
            check({name, "_no_done"}, got, 0);
        end
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b, mh, ml;
        logic        mdz;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max"};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg3x7"};
        vecs[2] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minxmin"};
        vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7by2"};
        vecs[4] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, "divu_100by7"};
        vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf"};
        vecs[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, "div_7byneg2"};
        vecs[7] = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, "divu_by0"};
        vecs[8] = '{OP_DIVU,  32'd9,         32'd3,         32'd0,         32'd3,         1'b0, "divu_9by3"};
        vecs[9] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div_neg_by0"};

        rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", {busy, done, div_zero}, 3'b000);

        foreach (vecs[i])
            do_md(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 0);

        // Back-to-back MTHI then MTLO.
        start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF; src_b = '0;
        @(posedge clk); #1;
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_done", done, 1);
        check("mthi_busy", busy, 0);
        op = OP_MTLO; src_a = 32'hCAFE_CAFE;
        @(posedge clk); #1;
        check("mtlo_lo", lo, 32'hCAFE_CAFE);
        check("mtlo_hi_kept", hi, 32'hDEAD_BEEF);
        check("mtlo_done", done, 1);
        check("mtlo_busy", busy, 0);
        start = 1'b0;
        @(posedge clk); #1;
        check("mtx_done_clr", done, 0);
        model_hi = 32'hDEAD_BEEF;
        model_lo = 32'hCAFE_CAFE;

        // Reserved opcode is ignored.
        start = 1'b1; op = 3'b110; src_a = 32'h5555_5555;
        @(posedge clk); #1;
        start = 1'b0;
        check("op110_ignored", {busy, done, hi, lo}, {2'b00, model_hi, model_lo});

        // MULT with an MTLO attempt while busy.
        do_md("mult_inj", OP_MULT, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, 5);

        // Asynchronous reset in the middle of iteration 10.
        issue(OP_MULT, 32'h0001_2345, 32'h0000_0777);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        @(posedge clk); #1;
        check("after_rst_idle", busy, 0);
        do_md("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'($urandom_range(0, 1000));
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(o, a, b, mh, ml, mdz);
            do_md("rand", o, a, b, mh, ml, mdz, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
